// File: rtl/gost89_round.sv
// One Feistel round of the GOST 28147-89 block cipher.
// The round function output is XORed into n2 and the halves are swapped,
// with both results registered. The caller iterates this block 32 times,
// feeding out1 back to n1 and out2 back to n2 and presenting a new subkey
// each cycle.
module gost89_round (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] sbox,
    input  logic [31:0]  key,
    input  logic [31:0]  n1,
    input  logic [31:0]  n2,
    output logic [31:0]  out1,
    output logic [31:0]  out2
);

    logic [31:0] sum;
    logic [31:0] sub;
    logic [31:0] f_out;

    // Key mixing: plain 32-bit add, the carry out of bit 31 is dropped.
    always_comb begin
        sum = n1 + key;
    end

    // Substitution: nibble i of the sum picks entry j of box i.
    // Bit address of entry j in box i is 64*i + 4*j = {i, j, 2'b00}.
    always_comb begin
        // NOTE: a full default before the loop means every bit is assigned on
        // every pass, so no latch can be inferred.
        sub = '0;
        for (int i = 0; i < 8; i++) begin
            sub[4*i +: 4] = sbox[{i[2:0], sum[4*i +: 4], 2'b00} +: 4];
        end
    end

    // Rotate the substituted word left by 11 bits.
    assign f_out = {sub[20:0], sub[31:21]};

    // Register the round result; reset clears both halves immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out1 <= '0;
            out2 <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values present before the edge, whatever the statement order.
            out1 <= n2 ^ f_out;
            out2 <= n1;
        end
    end

endmodule

// File: tb/tb_gost89_round.sv
// Self-checking bench for gost89_round: a driver pushes expected results into
// a scoreboard queue tagged with the clock edge that must produce them, and
// an independent monitor compares the registered outputs on each falling edge.
module tb_gost89_round;

    logic         clk;
    logic         reset;
    logic [511:0] sbox;
    logic [31:0]  key;
    logic [31:0]  n1;
    logic [31:0]  n2;
    logic [31:0]  out1;
    logic [31:0]  out2;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    typedef struct {
        int          edge_no;
        logic [31:0] o1;
        logic [31:0] o2;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    gost89_round dut (
        .clk  (clk),
        .reset(reset),
        .sbox (sbox),
        .key  (key),
        .n1   (n1),
        .n2   (n2),
        .out1 (out1),
        .out2 (out2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] box_entry(input logic [511:0] s, input int box, input int idx);
        logic [511:0] sh;
        sh = s >> (64 * box + 4 * idx);
        return sh[3:0];
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [31:0] k,
                                          input logic [511:0] s);
        logic [31:0] sum;
        logic [31:0] t;
        logic [31:0] nib;
        sum = x + k;
        t = 32'h0;
        for (int i = 0; i < 8; i++) begin
            nib = (sum >> (4 * i)) & 32'hF;
            t = t | ({28'h0, box_entry(s, i, int'(nib))} << (4 * i));
        end
        return (t << 11) | (t >> 21);
    endfunction

    function automatic logic [511:0] identity_sbox();
        logic [511:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 16; j++)
                s = s | ({508'h0, 4'(j)} << (64 * i + 4 * j));
        return s;
    endfunction

    function automatic logic [511:0] random_sbox();
        logic [511:0] s;
        for (int w = 0; w < 16; w++) s[32*w +: 32] = $urandom;
        return s;
    endfunction

    // GOST ECB encryption: 31 rounds with half swap, final round without swap.
    // N1 = pt[31:0], N2 = pt[63:32]; result is {N1, N2}.
    function automatic logic [63:0] gost_ecb(input logic [63:0] pt, input logic [31:0] k8 [8],
                                             input logic [511:0] s);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = pt[31:0];
        b = pt[63:32];
        for (int r = 0; r < 32; r++) begin
            if (r == 31) begin
                b = b ^ ref_f(a, k8[7 - (r % 8)], s);
            end else begin
                t = b ^ ref_f(a, (r < 24) ? k8[r % 8] : k8[7 - (r % 8)], s);
                b = a;
                a = t;
            end
        end
        return {a, b};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.edge_no < edge_cnt) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: result for edge %0d not observed, now at edge %0d",
                         e.name, e.edge_no, edge_cnt);
            end else begin
                check(e.name, {out1, out2}, {e.o1, e.o2});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input string name, input logic [511:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] k,
                         input logic [31:0] e1, input logic [31:0] e2);
        @(negedge clk);
        sbox = s;
        n1   = a;
        n2   = b;
        key  = k;
        sb_q.push_back('{edge_cnt + 1, e1, e2, name});
    endtask

    task automatic drive_model(input string name, input logic [511:0] s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] k);
        drive(name, s, a, b, k, b ^ ref_f(a, k, s), a);
    endtask

    // Runs the 32-round feedback loop; stops early with reset at abort_round if >= 0.
    task automatic feedback_run(input string name, input int abort_round);
        logic [31:0]  k8 [8];
        logic [63:0]  pt;
        logic [511:0] s;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  kr;
        logic [31:0]  t;
        for (int i = 0; i < 8; i++) k8[i] = $urandom;
        pt = {$urandom, $urandom};
        s  = random_sbox();
        a  = pt[31:0];
        b  = pt[63:32];
        for (int r = 0; r < 32; r++) begin
            if (r == abort_round) begin
                @(negedge clk);
                #2 reset = 1'b0;
                #1 check({name, "_reset_now"}, {out1, out2}, 64'h0);
                @(negedge clk);
                check({name, "_reset_held"}, {out1, out2}, 64'h0);
                #2;
                sbox = s;
                n1   = a;
                n2   = b;
                key  = k8[0];
                reset = 1'b1;
                sb_q.push_back('{edge_cnt + 1, b ^ ref_f(a, k8[0], s), a, {name, "_after_release"}});
                return;
            end
            kr = (r < 24) ? k8[r % 8] : k8[7 - (r % 8)];
            @(negedge clk);
            sbox = s;
            n1   = (r == 0) ? pt[31:0]  : out1;
            n2   = (r == 0) ? pt[63:32] : out2;
            key  = kr;
            t = b ^ ref_f(a, kr, s);
            sb_q.push_back('{edge_cnt + 1, t, a, $sformatf("%s_round%0d", name, r)});
            b = a;
            a = t;
        end
        @(negedge clk);
        check({name, "_ciphertext"}, {out2, out1}, gost_ecb(pt, k8, s));
    endtask

    logic [511:0] id_sb;
    logic [511:0] tmp_sb;

    initial begin
        id_sb = identity_sbox();
        reset = 1'b0;
        sbox  = random_sbox();
        key   = $urandom;
        n1    = $urandom;
        n2    = $urandom;
        #1 check("reset_t0", {out1, out2}, 64'h0);
        repeat (3) @(negedge clk);
        check("reset_clocked", {out1, out2}, 64'h0);

        // Release reset with the first computation already presented.
        #2;
        sbox = id_sb; n1 = 32'h0; n2 = 32'h0; key = 32'h1;
        reset = 1'b1;
        sb_q.push_back('{edge_cnt + 1, 32'h0000_0800, 32'h0, "first_after_reset"});

        drive("carry_wrap", id_sb, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1,
              32'h1234_5678, 32'hFFFF_FFFF);

        tmp_sb = '0; tmp_sb[3:0] = 4'h1;
        drive("box0_entry0", tmp_sb, 32'h0, 32'h0, 32'h0, 32'h0000_0800, 32'h0);
        tmp_sb = '0; tmp_sb[451:448] = 4'h1;
        drive("box7_entry0", tmp_sb, 32'h0, 32'h0, 32'h0, 32'h0000_0080, 32'h0);

        drive("all_ones_sbox", {512{1'b1}}, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h0102_0304,
              32'hF0F0_F0F0, 32'hDEAD_BEEF);

        for (int i = 0; i < 8; i++)
            drive_model($sformatf("pipe_id%0d", i), id_sb, $urandom, $urandom, $urandom);
        for (int i = 0; i < 16; i++)
            drive_model($sformatf("pipe_rand%0d", i), random_sbox(), $urandom, $urandom, $urandom);

        feedback_run("ecb_a", -1);
        feedback_run("ecb_b", -1);
        feedback_run("abort", 10);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d results never observed, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
